// File: rtl/prog_cntr_sel_unit.sv
// Fetch-stage program-counter source select with an integrated return-address stack.
// Picks the next PC by fixed priority (int > ret > call > branch > seq) and reports RAS errors.
module prog_cntr_sel_unit #(
  parameter int unsigned             ADDR_WIDTH   = 14,
  parameter int unsigned             RAS_DEPTH    = 4,
  parameter logic [ADDR_WIDTH-1:0]   RESET_VECTOR = '0
) (
  input  logic                               clock,
  input  logic                               reset,
  input  logic                               stall,
  input  logic                               branch_req,
  input  logic                               call_req,
  input  logic                               ret_req,
  input  logic                               int_req,
  input  logic [ADDR_WIDTH-1:0]              branch_target_addr,
  input  logic [ADDR_WIDTH-1:0]              int_branch_addr,
  input  logic                               err_clear,
  output logic [ADDR_WIDTH-1:0]              prog_cntr,
  output logic [ADDR_WIDTH-1:0]              next_prog_cntr,
  output logic [4:0]                         last_sel,
  output logic [$clog2(RAS_DEPTH+1)-1:0]     ras_count,
  output logic                               ras_overflow,
  output logic                               ras_underflow
);

  localparam int unsigned PTR_W = $clog2(RAS_DEPTH);
  localparam int unsigned CNT_W = $clog2(RAS_DEPTH + 1);

  localparam logic [4:0] SEL_SEQ = 5'b00001;
  localparam logic [4:0] SEL_BR  = 5'b00010;
  localparam logic [4:0] SEL_CAL = 5'b00100;
  localparam logic [4:0] SEL_RET = 5'b01000;
  localparam logic [4:0] SEL_INT = 5'b10000;

  logic [ADDR_WIDTH-1:0] r_pc;
  logic [4:0]            r_last_sel;
  logic [ADDR_WIDTH-1:0] r_ras [RAS_DEPTH];
  logic [PTR_W-1:0]      r_ptr;
  logic [CNT_W-1:0]      r_count;
  logic                  r_ovf;
  logic                  r_unf;

  logic [ADDR_WIDTH-1:0] w_pc_inc;
  logic [ADDR_WIDTH-1:0] w_ras_top;
  logic                  w_full;
  logic                  w_empty;
  logic [ADDR_WIDTH-1:0] w_pc_d;
  logic [4:0]            w_sel_d;
  logic                  w_push;
  logic                  w_pop;
  logic [ADDR_WIDTH-1:0] w_push_data;
  logic                  w_ovf_set;
  logic                  w_unf_set;
  logic [PTR_W-1:0]      w_ptr_d;
  logic [CNT_W-1:0]      w_count_d;

  assign w_pc_inc  = r_pc + ADDR_WIDTH'(1);
  assign w_full    = (r_count == CNT_W'(RAS_DEPTH));
  assign w_empty   = (r_count == '0);
  // r_ptr points at the next free slot, so the top lives one below it.
  assign w_ras_top = r_ras[r_ptr - PTR_W'(1)];

  // Priority select: one action per cycle, lower-priority requests dropped.
  always_comb begin
    w_pc_d      = w_pc_inc;
    w_sel_d     = SEL_SEQ;
    w_push      = 1'b0;
    w_pop       = 1'b0;
    w_push_data = r_pc;
    w_unf_set   = 1'b0;
    if (int_req) begin
      w_pc_d      = int_branch_addr;
      w_sel_d     = SEL_INT;
      w_push      = 1'b1;
      w_push_data = r_pc;
    end else if (ret_req) begin
      w_sel_d = SEL_RET;
      if (w_empty) begin
        w_unf_set = 1'b1;
      end else begin
        w_pc_d = w_ras_top;
        w_pop  = 1'b1;
      end
    end else if (call_req) begin
      w_pc_d      = branch_target_addr;
      w_sel_d     = SEL_CAL;
      w_push      = 1'b1;
      w_push_data = w_pc_inc;
    end else if (branch_req) begin
      w_pc_d  = branch_target_addr;
      w_sel_d = SEL_BR;
    end
  end

  assign w_ovf_set = w_push & w_full;

  // Circular stack: a push when full overwrites the oldest entry and the count saturates.
  always_comb begin
    w_ptr_d   = r_ptr;
    w_count_d = r_count;
    if (w_push) begin
      w_ptr_d = r_ptr + PTR_W'(1);
      if (!w_full) w_count_d = r_count + CNT_W'(1);
    end else if (w_pop) begin
      w_ptr_d   = r_ptr - PTR_W'(1);
      w_count_d = r_count - CNT_W'(1);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_pc       <= RESET_VECTOR;
      r_last_sel <= SEL_SEQ;
      r_ptr      <= '0;
      r_count    <= '0;
    end else if (!stall) begin
      r_pc       <= w_pc_d;
      r_last_sel <= w_sel_d;
      r_ptr      <= w_ptr_d;
      r_count    <= w_count_d;
    end
  end

  // Stack storage needs no reset; validity is tracked by r_count.
  always_ff @(posedge clock) begin
    if (!reset && !stall && w_push) r_ras[r_ptr] <= w_push_data;
  end

  // Sticky flags: clear honoured even under stall, a same-cycle error wins.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_ovf <= 1'b0;
      r_unf <= 1'b0;
    end else begin
      r_ovf <= (r_ovf & ~err_clear) | (w_ovf_set & ~stall);
      r_unf <= (r_unf & ~err_clear) | (w_unf_set & ~stall);
    end
  end

  assign prog_cntr      = r_pc;
  assign next_prog_cntr = w_pc_inc;
  assign last_sel       = r_last_sel;
  assign ras_count      = r_count;
  assign ras_overflow   = r_ovf;
  assign ras_underflow  = r_unf;

endmodule

// File: tb/tb_prog_cntr_sel_unit.sv
// Self-checking bench for prog_cntr_sel_unit: vector table with a scoreboard queue,
// plus hand-built sequences for async reset during a call.
module tb_prog_cntr_sel_unit;

  typedef struct {
    logic        st, br, ca, re, in, cl;
    logic [13:0] tgt, iaddr;
    logic [13:0] pc;
    logic [4:0]  sel;
    logic [2:0]  cnt;
    logic        ovf, unf;
  } vec_t;

  typedef struct {
    logic [13:0] pc;
    logic [4:0]  sel;
    logic [2:0]  cnt;
    logic        ovf, unf;
  } exp_t;

  logic        clock = 1'b0;
  logic        reset;
  logic        stall, branch_req, call_req, ret_req, int_req, err_clear;
  logic [13:0] branch_target_addr, int_branch_addr;
  logic [13:0] prog_cntr, next_prog_cntr;
  logic [4:0]  last_sel;
  logic [2:0]  ras_count;
  logic        ras_overflow, ras_underflow;

  int n_pass = 0;
  int n_tot  = 0;

  vec_t tbl[$];
  exp_t exp_q[$];

  prog_cntr_sel_unit #(.ADDR_WIDTH(14), .RAS_DEPTH(4), .RESET_VECTOR(14'd0)) dut (
    .clock              (clock),
    .reset              (reset),
    .stall              (stall),
    .branch_req         (branch_req),
    .call_req           (call_req),
    .ret_req            (ret_req),
    .int_req            (int_req),
    .branch_target_addr (branch_target_addr),
    .int_branch_addr    (int_branch_addr),
    .err_clear          (err_clear),
    .prog_cntr          (prog_cntr),
    .next_prog_cntr     (next_prog_cntr),
    .last_sel           (last_sel),
    .ras_count          (ras_count),
    .ras_overflow       (ras_overflow),
    .ras_underflow      (ras_underflow)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic vec_t mk(input logic st, br, ca, re, in, cl,
                              input logic [13:0] tgt, iaddr, pc,
                              input logic [4:0] sel, input logic [2:0] cnt,
                              input logic ovf, unf);
    vec_t v;
    v.st = st; v.br = br; v.ca = ca; v.re = re; v.in = in; v.cl = cl;
    v.tgt = tgt; v.iaddr = iaddr; v.pc = pc; v.sel = sel; v.cnt = cnt;
    v.ovf = ovf; v.unf = unf;
    return v;
  endfunction

  task automatic idle_inputs();
    stall = 0; branch_req = 0; call_req = 0; ret_req = 0; int_req = 0; err_clear = 0;
    branch_target_addr = '0; int_branch_addr = '0;
  endtask

  task automatic check_state(input string tag, input exp_t e);
    chk({tag, ".pc"},  32'(prog_cntr), 32'(e.pc));
    chk({tag, ".npc"}, 32'(next_prog_cntr), 32'(14'(e.pc + 14'd1)));
    chk({tag, ".sel"}, 32'(last_sel), 32'(e.sel));
    chk({tag, ".cnt"}, 32'(ras_count), 32'(e.cnt));
    chk({tag, ".ovf"}, 32'(ras_overflow), 32'(e.ovf));
    chk({tag, ".unf"}, 32'(ras_underflow), 32'(e.unf));
  endtask

  // Drive one vector, queue its expectation, and compare it once the edge has produced it.
  task automatic run_vec(input int idx, input vec_t v);
    exp_t e;
    stall = v.st; branch_req = v.br; call_req = v.ca; ret_req = v.re; int_req = v.in;
    err_clear = v.cl; branch_target_addr = v.tgt; int_branch_addr = v.iaddr;
    e.pc = v.pc; e.sel = v.sel; e.cnt = v.cnt; e.ovf = v.ovf; e.unf = v.unf;
    exp_q.push_back(e);
    @(posedge clock);
    #1;
    if (exp_q.size() == 0) begin
      n_tot++;
      $display("FAIL scoreboard: queue empty at row %0d", idx);
    end else begin
      check_state($sformatf("row%0d", idx), exp_q.pop_front());
    end
  endtask

  initial begin
    exp_t e;
    idle_inputs();
    reset = 1'b1;
    #12 reset = 1'b0;

    e = '{pc: 14'd0, sel: 5'b00001, cnt: 3'd0, ovf: 1'b0, unf: 1'b0};
    check_state("reset", e);

    //                 st br ca re in cl  tgt       iaddr     pc        sel       cnt ovf unf
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 14'd0,    14'd0,    14'd1,    5'b00001, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 14'd0,    14'd0,    14'd2,    5'b00001, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 14'd0,    14'd0,    14'd3,    5'b00001, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 14'd10,   14'd0,    14'd10,   5'b00010, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0, 0, 0, 14'd100,  14'd0,    14'd100,  5'b00100, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 0, 0, 14'd0,    14'd0,    14'd11,   5'b01000, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 14'd20,   14'd0,    14'd20,   5'b00010, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 1, 1, 0, 14'd5,    14'h3F00, 14'h3F00, 5'b10000, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 0, 0, 14'd0,    14'd0,    14'd20,   5'b01000, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 14'd1,    14'd0,    14'd1,    5'b00010, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0, 0, 0, 14'd2,    14'd0,    14'd2,    5'b00100, 1, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0, 0, 0, 14'd3,    14'd0,    14'd3,    5'b00100, 2, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0, 0, 0, 14'd4,    14'd0,    14'd4,    5'b00100, 3, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0, 0, 0, 14'd5,    14'd0,    14'd5,    5'b00100, 4, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0, 0, 0, 14'd50,   14'd0,    14'd50,   5'b00100, 4, 1, 0));
    tbl.push_back(mk(0, 0, 0, 1, 0, 0, 14'd0,    14'd0,    14'd6,    5'b01000, 3, 1, 0));
    tbl.push_back(mk(0, 0, 0, 1, 0, 0, 14'd0,    14'd0,    14'd5,    5'b01000, 2, 1, 0));
    tbl.push_back(mk(0, 0, 0, 1, 0, 0, 14'd0,    14'd0,    14'd4,    5'b01000, 1, 1, 0));
    tbl.push_back(mk(0, 0, 0, 1, 0, 0, 14'd0,    14'd0,    14'd3,    5'b01000, 0, 1, 0));
    tbl.push_back(mk(0, 0, 0, 1, 0, 0, 14'd0,    14'd0,    14'd4,    5'b01000, 0, 1, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 14'd0,    14'd0,    14'd5,    5'b00001, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 14'h3FFF, 14'd0,    14'h3FFF, 5'b00010, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 14'd0,    14'd0,    14'd0,    5'b00001, 0, 0, 0));
    tbl.push_back(mk(1, 1, 0, 0, 0, 0, 14'd77,   14'd0,    14'd0,    5'b00001, 0, 0, 0));
    tbl.push_back(mk(1, 1, 0, 0, 0, 0, 14'd77,   14'd0,    14'd0,    5'b00001, 0, 0, 0));
    tbl.push_back(mk(1, 1, 0, 0, 0, 0, 14'd77,   14'd0,    14'd0,    5'b00001, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 0, 0, 14'd0,    14'd0,    14'd1,    5'b01000, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 1, 0, 1, 14'd0,    14'd0,    14'd2,    5'b01000, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 14'd0,    14'd0,    14'd3,    5'b00001, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 0, 0, 14'd0,    14'd0,    14'd4,    5'b01000, 0, 0, 1));
    tbl.push_back(mk(1, 0, 0, 1, 0, 1, 14'd0,    14'd0,    14'd4,    5'b01000, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 14'd0,    14'd0,    14'd5,    5'b00001, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0, 0, 0, 14'd40,   14'd0,    14'd40,   5'b00100, 1, 0, 0));
    tbl.push_back(mk(1, 0, 0, 1, 0, 0, 14'd0,    14'd0,    14'd40,   5'b00100, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 0, 0, 14'd0,    14'd0,    14'd6,    5'b01000, 0, 0, 0));

    @(posedge clock);
    #1;
    // Realign: the reset-state check happened off-grid, so restart from a known PC.
    exp_q.delete();
    // The extra edge above advanced PC 0 -> 1; rewind via async reset to keep the table valid.
    reset = 1'b1;
    #1 reset = 1'b0;

    for (int i = 0; i < tbl.size(); i++) run_vec(i, tbl[i]);

    // Async reset asserted mid-cycle while a call is being presented.
    call_req = 1'b1;
    branch_target_addr = 14'd200;
    #3 reset = 1'b1;
    #1;
    e = '{pc: 14'd0, sel: 5'b00001, cnt: 3'd0, ovf: 1'b0, unf: 1'b0};
    check_state("async_rst", e);
    idle_inputs();
    #2 reset = 1'b0;
    run_vec(100, mk(0, 0, 0, 0, 0, 0, 14'd0, 14'd0, 14'd1, 5'b00001, 0, 0, 0));
    // A return now must find an empty stack: the interrupted call left nothing behind.
    run_vec(101, mk(0, 0, 0, 1, 0, 0, 14'd0, 14'd0, 14'd2, 5'b01000, 0, 0, 1));

    if (exp_q.size() != 0) begin
      n_tot++;
      $display("FAIL scoreboard: %0d entries left", exp_q.size());
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule

// File: doc/prog_cntr_sel_unit.md
Name: prog_cntr_sel_unit

Overview:
- Parametrised successor to the fetch-stage program-counter load mux.
- Selects the next fetch address from sequential, branch, call, return and interrupt sources by fixed priority, and holds it in the PC register.
- Integrates a hardware return-address stack (RAS), so return addresses no longer come from outside the fetch stage.
- Sits in the fetch stage; drives the instruction-memory address and reports stack errors to the control unit.

Parameters:
- ADDR_WIDTH, 14: width of every address and of the PC.
- RAS_DEPTH, 4: number of RAS entries; must be a power of 2 and at least 2.
- RESET_VECTOR, 0: PC value on reset.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- stall  in  1  hold PC and RAS; all requests ignored.
- branch_req  in  1  load branch_target_addr.
- call_req  in  1  load branch_target_addr and push next_prog_cntr.
- ret_req  in  1  load the RAS top and pop.
- int_req  in  1  load int_branch_addr and push prog_cntr.
- branch_target_addr  in  ADDR_WIDTH  branch/call target.
- int_branch_addr  in  ADDR_WIDTH  interrupt vector.
- err_clear  in  1  clear the sticky error flags.
- prog_cntr  out  ADDR_WIDTH  current fetch address (registered).
- next_prog_cntr  out  ADDR_WIDTH  prog_cntr+1, combinational.
- last_sel  out  5  registered one-hot of the source loaded last cycle: [0] seq, [1] branch, [2] call, [3] ret, [4] int.
- ras_count  out  clog2(RAS_DEPTH+1)  number of valid RAS entries.
- ras_overflow  out  1  sticky: a push occurred while the RAS was full.
- ras_underflow  out  1  sticky: a pop occurred while the RAS was empty.

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - prog_cntr = RESET_VECTOR
  - last_sel = 5'b00001
  - ras_count = 0, RAS pointer = 0
  - ras_overflow = 0, ras_underflow = 0
  - RAS contents are don't-care.
- Reset asserted mid-operation discards any in-flight push or pop; the first edge after release behaves as a normal cycle.
- Arithmetic:
  - next_prog_cntr = (prog_cntr + 1) mod 2^ADDR_WIDTH; the all-ones address wraps to 0.
  - RAS pointer wraps mod RAS_DEPTH.
- Update latency: the selected address appears on prog_cntr one clock after the request is sampled.
- Priority, evaluated each non-stalled rising edge: int > ret > call > branch > seq.
  - Exactly one action is taken per cycle; lower-priority requests in the same cycle are dropped with no RAS side effect.
- Actions:
  - int: prog_cntr <= int_branch_addr; push prog_cntr (the squashed fetch is re-executed on return).
  - ret, RAS non-empty: prog_cntr <= RAS top; pop.
  - ret, RAS empty: prog_cntr <= next_prog_cntr; no pop; ras_underflow <= 1.
  - call: prog_cntr <= branch_target_addr; push next_prog_cntr.
  - branch: prog_cntr <= branch_target_addr.
  - none: prog_cntr <= next_prog_cntr.
- Push when full:
  - Overwrite the oldest entry (circular buffer); the pointer advances.
  - ras_count stays at RAS_DEPTH; ras_overflow <= 1.
- last_sel records the action taken and is one-hot in every non-stalled cycle.
- stall = 1:
  - prog_cntr, RAS, ras_count and last_sel all hold.
  - Requests are lost; the requester must hold its request until stall drops.
  - The error flags still honour err_clear.
- err_clear clears both sticky flags at the edge. If a new error occurs in the same cycle, set wins.
- next_prog_cntr and ras_count are valid in every cycle, including during stall.

Test Plan:
- Release reset with RESET_VECTOR=0 and no requests for 3 clocks -> prog_cntr 0,1,2,3; last_sel 00001.
- prog_cntr=10, call_req with target 100 -> prog_cntr=100, ras_count=1. Then ret_req -> prog_cntr=11, ras_count=0, last_sel 01000.
- int_req, ret_req and branch_req together at prog_cntr=20 with int_branch_addr=0x3F00 -> prog_cntr=0x3F00, ras_count=1 (top=20), ret and branch dropped.
- Five calls at PC 1,2,3,4,5 with RAS_DEPTH=4 -> ras_overflow=1, ras_count=4. Four returns -> 6,5,4,3. Fifth return -> next_prog_cntr, ras_underflow=1.
- prog_cntr=0x3FFF with no request -> 0; stall held 3 cycles with branch_req -> prog_cntr unchanged; err_clear with a simultaneous underflow -> flag stays 1.
- Assert reset asynchronously mid-cycle during a call -> prog_cntr=RESET_VECTOR immediately, ras_count=0, no push recorded.
